// File: rtl/reset_btn_ctrl.sv
// reset_btn_ctrl
//   Button debouncer with press/release pulses plus a system reset sequencer
//   that waits for all PLLs to lock, holds reset for a fixed time, and can be
//   re-entered by a dedicated reset button or by loss of lock.
//
// Ports
//   clk            : single clock, rising edge
//   reset_i        : synchronous active-high reset
//   btn_i          : raw asynchronous button pins (polarity set per bit by BTN_ACTIVE_LOW)
//   pll_locked_i   : raw asynchronous PLL lock flags
//   btn_o          : debounced button levels, 1 = pressed
//   btn_press_o    : one-cycle pulse when a debounced level rises
//   btn_release_o  : one-cycle pulse when a debounced level falls
//   reset_o        : system reset, active-high
//   reset_cause_o  : last reset cause (0 power-on, 1 button, 2 lock loss)
//   locked_o       : AND of the synchronized lock flags
module reset_btn_ctrl #(
    parameter int                 NUM_BTN           = 7,
    parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW    = 7'b0000001,
    parameter int                 DEBOUNCE_CYCLES   = 16,
    parameter int                 NUM_LOCK          = 2,
    parameter int                 RESET_HOLD_CYCLES = 31,
    parameter int                 RESET_BTN_IDX     = 0
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic [NUM_BTN-1:0]  btn_i,
    input  logic [NUM_LOCK-1:0] pll_locked_i,
    output logic [NUM_BTN-1:0]  btn_o,
    output logic [NUM_BTN-1:0]  btn_press_o,
    output logic [NUM_BTN-1:0]  btn_release_o,
    output logic                reset_o,
    output logic [1:0]          reset_cause_o,
    output logic                locked_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    // The level flips on the edge where the counter would reach
    // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RESET_HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_BUTTON    = 2'd1;
    localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd2;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    // Synchronizers
    logic [NUM_BTN-1:0]  btn_s1_q, btn_s2_q;
    logic [NUM_LOCK-1:0] lock_s1_q, lock_s2_q;

    // Debounce state
    logic [NUM_BTN-1:0]  btn_sync;
    logic [DBW-1:0]      dbc_q [NUM_BTN];
    logic [DBW-1:0]      dbc_d [NUM_BTN];
    logic [NUM_BTN-1:0]  btn_q, btn_d;
    logic [NUM_BTN-1:0]  press_q, press_d;
    logic [NUM_BTN-1:0]  release_q, release_d;

    // Reset sequencer state
    state_t              state_q, state_d;
    logic [HCW-1:0]      hold_q, hold_d;
    logic [1:0]          cause_q, cause_d;
    logic                reset_q, reset_d;
    logic                lock_ok;

    // Polarity is normalised after synchronization so every debounced level
    // reads 1 = pressed regardless of pin wiring.
    assign btn_sync = btn_s2_q ^ BTN_ACTIVE_LOW;
    assign lock_ok  = &lock_s2_q;

    always_comb begin
        btn_d     = btn_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            dbc_d[i] = '0;
            if (btn_sync[i] != btn_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    btn_d[i]     = ~btn_q[i];
                    press_d[i]   = ~btn_q[i];
                    release_d[i] = btn_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + DBW'(1);
                end
            end
        end
    end

    // The sequencer reacts to the registered outputs (locked_o, btn_o,
    // btn_press_o) as a downstream observer would see them, so a lock drop
    // and a reset-button press visible in the same cycle are resolved
    // together on the following edge, with lock loss taking priority.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_HOLD: begin
                if (!lock_ok) begin
                    state_d = ST_WAIT_LOCK;
                end else if (btn_q[RESET_BTN_IDX]) begin
                    // Holding the reset button restarts the release timer.
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            ST_RUN: begin
                if (!lock_ok) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK_LOSS;
                end else if (press_q[RESET_BTN_IDX]) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    cause_d = CAUSE_BUTTON;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
        reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            lock_s1_q <= '0;
            lock_s2_q <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                dbc_q[i] <= '0;
            end
            state_q   <= ST_WAIT_LOCK;
            hold_q    <= '0;
            cause_q   <= '0;
            reset_q   <= 1'b1;
        end else begin
            btn_s1_q  <= btn_i;
            btn_s2_q  <= btn_s1_q;
            lock_s1_q <= pll_locked_i;
            lock_s2_q <= lock_s1_q;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                dbc_q[i] <= dbc_d[i];
            end
            state_q   <= state_d;
            hold_q    <= hold_d;
            cause_q   <= cause_d;
            reset_q   <= reset_d;
        end
    end

    assign btn_o         = btn_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;
    assign reset_o       = reset_q;
    assign reset_cause_o = cause_q;
    assign locked_o      = lock_ok;

endmodule
